// File: rtl/fir_pkg.sv
// fir_pkg: FIR shared state enum, default tap count/width, tap-index width helper
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam int DEF_NTAPS = 3;
  localparam int DEF_W = 8;
  function automatic int tap_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_KW = tap_w(DEF_NTAPS);
endpackage

// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: coeff write port (we/addr/data/err), sample in (valid/ready/x), result out (valid/ready/y), busy; master = source/sink, slave = filter
interface fir_mac_sched_if
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int W = DEF_W
);
  logic coeff_we;
  logic [tap_w(NTAPS)-1:0] coeff_addr;
  logic [W-1:0] coeff_data;
  logic coeff_err;
  logic x_valid;
  logic x_ready;
  logic [W-1:0] x;
  logic y_valid;
  logic y_ready;
  logic [W-1:0] y;
  logic busy;
  modport master (
    output coeff_we, coeff_addr, coeff_data, x_valid, x, y_ready,
    input coeff_err, x_ready, y_valid, y, busy
  );
  modport slave (
    input coeff_we, coeff_addr, coeff_data, x_valid, x, y_ready,
    output coeff_err, x_ready, y_valid, y, busy
  );
endinterface

// File: rtl/fir_mac_dp.sv
// fir_mac_dp: delay line, coefficient bank and W-bit wrapping MAC; in: clk/rst, shift/x, we/waddr/wdata, clr/mac/k; out: sum (acc + coeff[k]*tap[k])
module fir_mac_dp
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int W = DEF_W,
  parameter int KW = tap_w(NTAPS)
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic we,
  input  logic clr,
  input  logic mac,
  input  logic [W-1:0] x,
  input  logic [W-1:0] wdata,
  input  logic [KW-1:0] waddr,
  input  logic [KW-1:0] k,
  output logic [W-1:0] sum
);
  logic [W-1:0] tap [NTAPS];
  logic [W-1:0] coeff [NTAPS];
  logic [W-1:0] acc;
  assign sum = acc + W'(coeff[k] * tap[k]);
  always_ff @(posedge clk)
    if (rst) begin
      tap <= '{default: '0};
      coeff <= '{default: '0};
      acc <= '0;
    end else begin
      if (shift) begin
        tap[0] <= x;
        for (int i = 1; i < NTAPS; i++) tap[i] <= tap[i-1];
      end
      if (we) coeff[waddr] <= wdata;
      acc <= clr ? '0 : mac ? sum : acc;
    end
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR controller; ports clk, rst and bus (slave: coeff write, sample in, result out, busy)
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int W = DEF_W
) (
  input logic clk,
  input logic rst,
  fir_mac_sched_if.slave bus
);
  localparam int KW = tap_w(NTAPS);
  localparam logic [KW-1:0] LAST = KW'(NTAPS - 1);
  state_t state;
  logic [KW-1:0] k;
  logic [W-1:0] sum;
  logic accept;
  logic wr_ok;
  assign accept = state == IDLE && bus.x_valid;
  assign wr_ok = bus.coeff_we && state == IDLE && bus.coeff_addr <= LAST;
  assign bus.x_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  fir_mac_dp #(.NTAPS(NTAPS), .W(W), .KW(KW)) dp (
    .clk(clk),
    .rst(rst),
    .shift(accept),
    .we(wr_ok),
    .clr(accept),
    .mac(state == MAC),
    .x(bus.x),
    .wdata(bus.coeff_data),
    .waddr(bus.coeff_addr),
    .k(k),
    .sum(sum)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      k <= '0;
      bus.y <= '0;
      bus.y_valid <= 1'b0;
      bus.coeff_err <= 1'b0;
    end else begin
      bus.coeff_err <= bus.coeff_we && !wr_ok;
      case (state)
        IDLE: if (bus.x_valid) begin
          state <= MAC;
          k <= '0;
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == LAST) begin
            bus.y <= sum;
            bus.y_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: if (bus.y_ready) begin
          bus.y_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: directed and random checks of fir_mac_sched against an arithmetic FIR model
module tb_fir_mac_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int mcoef [3];
  int mtap [3];
  int last_y;
  always #5 clk = ~clk;
  fir_mac_sched_if #(.NTAPS(3), .W(8)) bus ();
  fir_mac_sched #(.NTAPS(3), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clear_model;
    for (int i = 0; i < 3; i++) begin
      mcoef[i] = 0;
      mtap[i] = 0;
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.coeff_we = 1'b1;
    bus.coeff_addr = a;
    bus.coeff_data = d;
    tick;
    chk("wr_err", bus.coeff_err, a == 2'd3);
    bus.coeff_we = 1'b0;
    if (a != 2'd3) mcoef[a] = d;
    tick;
    chk("wr_err_clear", bus.coeff_err, 0);
  endtask
  // mode 0: no write, 1: write on the accept edge, 2: write during the first MAC cycle
  task automatic run_sample(input logic [7:0] xv, input int hold, input logic keep,
                            input int mode, input logic [1:0] wa, input logic [7:0] wd);
    int exp_y;
    bus.x = xv;
    bus.x_valid = 1'b1;
    bus.y_ready = hold == 0;
    if (mode == 1) begin
      bus.coeff_we = 1'b1;
      bus.coeff_addr = wa;
      bus.coeff_data = wd;
    end
    chk("x_ready_idle", bus.x_ready, 1);
    tick;
    chk("busy_after_accept", bus.busy, 1);
    if (mode == 1) begin
      chk("accept_wr_err", bus.coeff_err, wa == 2'd3);
      bus.coeff_we = 1'b0;
      if (wa != 2'd3) mcoef[wa] = wd;
    end
    bus.x_valid = keep;
    bus.x = 8'($urandom);
    mtap[2] = mtap[1];
    mtap[1] = mtap[0];
    mtap[0] = xv;
    exp_y = 0;
    for (int i = 0; i < 3; i++) exp_y += mcoef[i] * mtap[i];
    exp_y = exp_y % 256;
    if (mode == 2) begin
      bus.coeff_we = 1'b1;
      bus.coeff_addr = wa;
      bus.coeff_data = wd;
    end
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("latency_valid", bus.y_valid, i == 3);
      chk("x_ready_busy", bus.x_ready, 0);
      if (mode == 2 && i < 3) begin
        chk("mac_wr_err", bus.coeff_err, i == 1);
        bus.coeff_we = 1'b0;
      end
    end
    chk("y", bus.y, exp_y);
    repeat (hold) begin
      tick;
      chk("hold_valid", bus.y_valid, 1);
      chk("hold_y", bus.y, exp_y);
      chk("hold_x_ready", bus.x_ready, 0);
    end
    bus.y_ready = 1'b1;
    tick;
    chk("hs_valid_low", bus.y_valid, 0);
    chk("hs_idle", bus.x_ready, 1);
    last_y = exp_y;
  endtask
  initial begin
    bus.coeff_we = 1'b0;
    bus.coeff_addr = '0;
    bus.coeff_data = '0;
    bus.x_valid = 1'b0;
    bus.x = '0;
    bus.y_ready = 1'b0;
    clear_model();
    tick;
    tick;
    rst = 1'b0;
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_x_ready", bus.x_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_coeff_err", bus.coeff_err, 0);
    chk("rst_y", bus.y, 0);
    wr(2'd0, 8'd1);
    wr(2'd1, 8'd2);
    wr(2'd2, 8'd3);
    run_sample(8'd1, 0, 1'b0, 0, 2'd0, 8'd0);
    chk("plan_y1", last_y, 1);
    run_sample(8'd2, 0, 1'b0, 0, 2'd0, 8'd0);
    chk("plan_y2", last_y, 4);
    run_sample(8'd3, 0, 1'b0, 0, 2'd0, 8'd0);
    chk("plan_y3", last_y, 10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) wr(2'(i), 8'd255);
    for (int i = 1; i <= 3; i++) begin
      run_sample(8'd255, 0, 1'b0, 0, 2'd0, 8'd0);
      chk("wrap_y", last_y, i);
    end
    run_sample(8'd7, 10, 1'b0, 0, 2'd0, 8'd0);
    run_sample(8'd20, 0, 1'b0, 2, 2'd1, 8'd9);
    wr(2'd3, 8'd5);
    run_sample(8'd30, 0, 1'b0, 1, 2'd0, 8'd77);
    wr(2'd0, 8'd11);
    wr(2'd1, 8'd12);
    wr(2'd2, 8'd13);
    bus.x = 8'd9;
    bus.x_valid = 1'b1;
    tick;
    bus.x_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clear_model();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_y_valid", bus.y_valid, 0);
    chk("midrst_y", bus.y, 0);
    chk("midrst_x_ready", bus.x_ready, 1);
    run_sample(8'd5, 0, 1'b0, 0, 2'd0, 8'd0);
    chk("midrst_y5", last_y, 0);
    for (int i = 0; i < 3; i++) wr(2'(i), 8'($urandom));
    for (int n = 0; n < 200; n++) run_sample(8'($urandom), 0, 1'b1, 0, 2'd0, 8'd0);
    bus.x_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
